dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have these pipeline request inputs:
- rvalid (1): read request.
- wvalid (1): write request.
- op (1): 0 = read, 1 = write; decides the request type when it is captured.
- addr (32): byte address.
- wdata (32): store data, right-aligned.
- wstrb (4): size, where 0001 = byte, 0011 = half, 1111 = word.
- is_atom (1): LL when reading, SC when writing.
REQ-005 SHALL have flush, input, 1 bit: discard the outstanding request.
REQ-006 SHALL have llbit_clear, input, 1 bit: clear the LL reservation (ERTN or exception).
REQ-007 SHALL have these pipeline response outputs:
- rready (1): one-cycle pulse, read done.
- rdata (32): read data, right-shifted by addr[1:0] bytes, no sign or zero extension.
- wready (1): one-cycle pulse, write done.
- sc_fail (1): valid with wready; SC not performed.
- ale (1): one-cycle pulse, misaligned access rejected.
- busy (1): high in any state other than IDLE.
- llbit (1): current reservation.
REQ-008 SHALL have these bus outputs: mem_req (1), mem_we (1), mem_addr (32, word-aligned), mem_wdata (32), mem_wstrb (4).
REQ-009 SHALL have these bus inputs: mem_gnt (1), mem_rvalid (1), mem_rdata (32).

Function
REQ-010 SHALL implement the FSM states IDLE, REQ, WAIT, RESP and DRAIN.
REQ-011 In IDLE, rvalid|wvalid SHALL capture op, addr, wdata, wstrb and is_atom; requests are ignored in every other state.
REQ-012 Misalignment SHALL be half with addr[0]=1, or word with addr[1:0]!=0.
REQ-013 A misaligned request SHALL go IDLE->RESP with ale=1 at RESP, no bus activity, and no rready/wready.
REQ-014 An SC captured while llbit=0 SHALL go IDLE->RESP with wready=1 and sc_fail=1, with no bus activity.
REQ-015 Any other captured request SHALL go IDLE->REQ.
REQ-016 In REQ, mem_req SHALL be 1, with mem_we = captured op and mem_addr = {addr[31:2],2'b00}.
REQ-017 In REQ, mem_wstrb SHALL be wstrb<<addr[1:0] and mem_wdata SHALL be wdata<<(8*addr[1:0]).
REQ-018 All bus outputs SHALL be held stable until mem_gnt.
REQ-019 On REQ with mem_gnt: a write SHALL go to RESP; a read SHALL go to WAIT.
REQ-020 In WAIT, mem_rvalid SHALL capture mem_rdata and go to RESP.
REQ-021 mem_rvalid in the same cycle as mem_gnt SHALL NOT be accepted; the bus returns read data at least one cycle after grant.
REQ-022 RESP SHALL last exactly one cycle, pulse the appropriate response output(s), then return to IDLE.
REQ-023 Minimum latency (request cycle = 0, grant in cycle 1, data in cycle 2) SHALL be:
- read: rready in cycle 3;
- write: wready in cycle 2;
- ale or SC-fail: response in cycle 1.
REQ-024 A successful SC (llbit=1) SHALL perform the bus write, return sc_fail=0 and clear llbit at RESP.
REQ-025 An LL completion SHALL set llbit at RESP.
REQ-026 llbit_clear SHALL clear llbit next cycle; if it coincides with an LL completion, the clear wins.
REQ-027 llbit SHALL be sampled for the SC decision in the capture cycle.
REQ-028 Flush SHALL behave by state:
- IDLE: no effect, and any request presented in the same cycle is dropped.
- REQ before grant: drop mem_req, go to IDLE, no response.
- REQ with mem_gnt in the same cycle: a read goes to DRAIN; a write is committed and its response suppressed.
- WAIT: go to DRAIN.
- RESP: response still pulses.
REQ-029 DRAIN SHALL wait for mem_rvalid, discard the data, issue no response and no llbit change, then go to IDLE.
REQ-030 rdata SHALL hold its last value outside RESP.
REQ-031 sc_fail and ale SHALL be 0 outside RESP.

Reset
REQ-032 On rst=1 the block SHALL be in IDLE with:
- rready, wready, sc_fail, ale, mem_req, mem_we, llbit and busy all 0;
- rdata, mem_addr, mem_wdata and mem_wstrb all 0.
REQ-033 rst SHALL override flush and in-flight bus state; a transaction granted before reset is abandoned, and the bus is required to tolerate this.

Verification
REQ-034 Word read, addr=0x1000_0004, gnt in cycle 1, rvalid with mem_rdata=0xDEADBEEF in cycle 2 -> rready=1 in cycle 3 with rdata=0xDEADBEEF.
REQ-035 Byte write, addr=0x1000_0003, wdata=0x000000A5, wstrb=0001 -> mem_addr=0x1000_0000, mem_wstrb=1000, mem_wdata=0xA5000000; wready one cycle after gnt.
REQ-036 Half read at addr=0x2 with mem_rdata=0x12345678 -> rdata=0x00001234; half read at addr=0x1 -> ale pulse in cycle 1, mem_req never asserted.
REQ-037 LL, then SC -> SC writes, sc_fail=0, llbit=0; a second SC -> wready with sc_fail=1 in cycle 1, no mem_req; LL completion coincident with llbit_clear -> llbit=0.
REQ-038 Read flushed in WAIT, rvalid 3 cycles later -> no rready, busy stays 1 until the cycle after rvalid, and the next request is accepted normally.
REQ-039 rst asserted while in WAIT -> next cycle IDLE, all outputs at their reset values, llbit=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Memory bus between the data-memory responder and the memory system.
//   master : responder side (drives request, consumes grant/read data)
//   slave  : memory side    (consumes request, drives grant/read data)
// Signals:
//   mem_req    request valid, held with all request fields until mem_gnt
//   mem_we     1 = write, 0 = read
//   mem_addr   word-aligned byte address
//   mem_wdata  lane-aligned store data
//   mem_wstrb  per-byte write enables, lane-aligned
//   mem_gnt    request accepted this cycle
//   mem_rvalid read data valid (never in the grant cycle)
//   mem_rdata  read data, full word
interface dmem_responder_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store (including LL/SC) from the
// pipeline at a time, checks alignment, issues it on the memory bus and
// returns a single-cycle response.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rvalid, wvalid     request strobes (sampled only while idle)
//   op                 0 = read, 1 = write
//   addr, wdata, wstrb byte address, right-aligned store data, size code
//   is_atom            LL on reads, SC on writes
//   flush              abandon the outstanding request
//   llbit_clear        drop the LL reservation
//   rready, rdata      read done pulse and right-shifted read data
//   wready, sc_fail    write done pulse, SC-not-performed flag
//   ale                misaligned access rejected pulse
//   busy, llbit        not idle, current reservation
//   bus                memory bus (master side)
module dmem_responder (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rvalid,
    input  logic                    wvalid,
    input  logic                    op,
    input  logic [31:0]             addr,
    input  logic [31:0]             wdata,
    input  logic [3:0]              wstrb,
    input  logic                    is_atom,
    input  logic                    flush,
    input  logic                    llbit_clear,
    output logic                    rready,
    output logic [31:0]             rdata,
    output logic                    wready,
    output logic                    sc_fail,
    output logic                    ale,
    output logic                    busy,
    output logic                    llbit,
    dmem_responder_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t      state_reg, state_next;

    logic        op_reg;
    logic        atom_reg;
    logic        ale_reg;
    logic        scfail_reg;
    logic [1:0]  off_reg;
    logic [31:0] rdata_reg;
    logic [31:0] mem_addr_reg;
    logic [31:0] mem_wdata_reg;
    logic [3:0]  mem_wstrb_reg;
    logic        llbit_reg;

    logic        capture;
    logic        misaligned;
    logic        sc_reject;
    logic        in_resp;
    logic        rdata_load;

    // Request decode, evaluated on the live inputs in the capture cycle.
    // llbit is sampled here, so a reservation change in the same cycle
    // does not affect this SC.
    always_comb begin
        capture    = (state_reg == S_IDLE) && (rvalid || wvalid) && !flush;
        misaligned = ((wstrb == 4'b0011) && addr[0]) ||
                     ((wstrb == 4'b1111) && (addr[1:0] != 2'b00));
        sc_reject  = op && is_atom && !llbit_reg;
    end

    always_comb begin
        state_next = state_reg;
        rdata_load = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (capture) begin
                    if (misaligned || sc_reject) begin
                        state_next = S_RESP;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_gnt) begin
                    // A granted write is already committed on the bus, so a
                    // flush only suppresses its response. A granted read
                    // still owes us a data beat, which must be drained.
                    if (op_reg) begin
                        state_next = flush ? S_IDLE : S_RESP;
                    end else begin
                        state_next = flush ? S_DRAIN : S_WAIT;
                    end
                end else if (flush) begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus.mem_rvalid) begin
                    // Data arriving together with a flush is simply dropped;
                    // nothing is left outstanding on the bus.
                    state_next = flush ? S_IDLE : S_RESP;
                    rdata_load = !flush;
                end else if (flush) begin
                    state_next = S_DRAIN;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (bus.mem_rvalid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            op_reg        <= 1'b0;
            atom_reg      <= 1'b0;
            ale_reg       <= 1'b0;
            scfail_reg    <= 1'b0;
            off_reg       <= 2'b00;
            rdata_reg     <= 32'h0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
            mem_wstrb_reg <= 4'h0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                op_reg        <= op;
                atom_reg      <= is_atom;
                ale_reg       <= misaligned;
                scfail_reg    <= !misaligned && sc_reject;
                off_reg       <= addr[1:0];
                mem_addr_reg  <= {addr[31:2], 2'b00};
                mem_wdata_reg <= wdata << {addr[1:0], 3'b000};
                mem_wstrb_reg <= wstrb << addr[1:0];
            end
            if (rdata_load) begin
                rdata_reg <= bus.mem_rdata >> {off_reg, 3'b000};
            end
        end
    end

    // Reservation: an explicit clear beats an LL completing in the same
    // cycle; a successful SC consumes the reservation.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit_reg <= 1'b0;
        end else if (llbit_clear) begin
            llbit_reg <= 1'b0;
        end else if (in_resp && !ale_reg && atom_reg) begin
            if (!op_reg) begin
                llbit_reg <= 1'b1;
            end else if (!scfail_reg) begin
                llbit_reg <= 1'b0;
            end
        end
    end

    always_comb begin
        in_resp       = (state_reg == S_RESP);
        rready        = in_resp && !ale_reg && !op_reg;
        wready        = in_resp && !ale_reg && op_reg;
        sc_fail       = in_resp && scfail_reg;
        ale           = in_resp && ale_reg;
        busy          = (state_reg != S_IDLE);
        llbit         = llbit_reg;
        rdata         = rdata_reg;
        bus.mem_req   = (state_reg == S_REQ);
        bus.mem_we    = (state_reg == S_REQ) && op_reg;
        bus.mem_addr  = mem_addr_reg;
        bus.mem_wdata = mem_wdata_reg;
        bus.mem_wstrb = mem_wstrb_reg;
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        rvalid, wvalid, op, is_atom, flush, llbit_clear;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        rready, wready, sc_fail, ale, busy, llbit;
    logic [31:0] rdata;

    dmem_responder_if bus_if ();

    dmem_responder dut (
        .clk         (clk),
        .rst         (rst),
        .rvalid      (rvalid),
        .wvalid      (wvalid),
        .op          (op),
        .addr        (addr),
        .wdata       (wdata),
        .wstrb       (wstrb),
        .is_atom     (is_atom),
        .flush       (flush),
        .llbit_clear (llbit_clear),
        .rready      (rready),
        .rdata       (rdata),
        .wready      (wready),
        .sc_fail     (sc_fail),
        .ale         (ale),
        .busy        (busy),
        .llbit       (llbit),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected responses (kind: 0 read, 1 write, 2 ale) and bus operations.
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic        scf;
    } resp_t;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } bus_t;

    resp_t exp_q[$];
    bus_t  bus_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [16];   // reference view of memory
    logic [31:0] bench_mem [16];   // memory behind the bus
    logic        model_ll = 1'b0;

    int gnt_dly = 0;
    int rd_dly  = 0;
    int issue_cyc = 0;
    int resp_cyc  = 0;
    bit saw_req   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model + request drive. Called at a negedge while idle.
    task automatic issue(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit atom, input bit push_resp);
        int    o, idx, nb;
        bit    mis;
        resp_t r;
        bus_t  b;
        o   = int'(a[1:0]);
        idx = int'(a[5:2]);
        nb  = (s == 4'b1111) ? 4 : (s == 4'b0011) ? 2 : 1;
        mis = (nb == 2 && a[0]) || (nb == 4 && o != 0);
        r.kind = 0; r.data = 32'h0; r.scf = 1'b0;
        if (mis) begin
            r.kind = 2;
        end else if (is_wr && atom && !model_ll) begin
            r.kind = 1;
            r.scf  = 1'b1;
        end else begin
            b.we   = is_wr;
            b.addr = {a[31:2], 2'b00};
            b.strb = 4'h0;
            for (int i = 0; i < nb; i++) b.strb[o + i] = 1'b1;
            b.data = d << (8 * o);
            bus_q.push_back(b);
            if (is_wr) begin
                for (int i = 0; i < nb; i++) model_mem[idx][8*(o+i) +: 8] = d[8*i +: 8];
                r.kind = 1;
                if (atom) model_ll = 1'b0;
            end else begin
                r.kind = 0;
                r.data = model_mem[idx] >> (8 * o);
                if (atom) model_ll = 1'b1;
            end
        end
        if (push_resp) exp_q.push_back(r);
        issue_cyc = cyc;
        rvalid  = !is_wr;
        wvalid  = is_wr;
        op      = is_wr;
        addr    = a;
        wdata   = d;
        wstrb   = s;
        is_atom = atom;
        @(negedge clk);
        rvalid  = 1'b0;
        wvalid  = 1'b0;
        op      = $urandom_range(0, 1);
        addr    = $urandom;
        wdata   = $urandom;
        is_atom = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    // Response monitor / scoreboard.
    initial begin
        resp_t e;
        int    kind;
        forever begin
            @(negedge clk);
            if (bus_if.mem_req) saw_req = 1;
            if (!rst && (rready || wready || ale)) begin
                resp_cyc = cyc;
                kind = ale ? 2 : (wready ? 1 : 0);
                chk("resp_onehot", 32'(rready) + 32'(wready) + 32'(ale), 32'd1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got kind %0d, required none", kind);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp cyc=%0d kind=%0d rdata=%h sc_fail=%b (exp kind=%0d data=%h scf=%b)",
                             cyc, kind, rdata, sc_fail, e.kind, e.data, e.scf);
                    chk("resp_kind", kind, e.kind);
                    if (e.kind == 0) chk("rdata", rdata, e.data);
                    if (e.kind == 1) chk("sc_fail", {31'b0, sc_fail}, {31'b0, e.scf});
                    if (e.kind == 2) chk("ale_scfail", {31'b0, sc_fail}, 32'h0);
                end
            end else if (!rst) begin
                chk("scfail_outside_resp", {31'b0, sc_fail}, 32'h0);
            end
        end
    end

    // Memory-side model: grant after gnt_dly cycles, read data rd_dly cycles
    // after the cycle following the grant.
    initial begin
        bus_t b;
        bit   gone, is_wr;
        int   wa;
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (bus_if.mem_req && !rst) begin
                gone = 0;
                for (int k = 0; k < gnt_dly; k++) begin
                    @(negedge clk);
                    if (!bus_if.mem_req || rst) begin
                        gone = 1;
                        break;
                    end
                end
                if (!gone) begin
                    is_wr = bus_if.mem_we;
                    wa    = int'(bus_if.mem_addr[5:2]);
                    if (bus_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_bus: got req addr %h, required none", bus_if.mem_addr);
                    end else begin
                        b = bus_q.pop_front();
                        chk("mem_we", {31'b0, bus_if.mem_we}, {31'b0, b.we});
                        chk("mem_addr", bus_if.mem_addr, b.addr);
                        if (b.we) begin
                            chk("mem_wstrb", {28'b0, bus_if.mem_wstrb}, {28'b0, b.strb});
                            chk("mem_wdata", bus_if.mem_wdata, b.data);
                        end
                    end
                    if (is_wr) begin
                        for (int i = 0; i < 4; i++)
                            if (bus_if.mem_wstrb[i]) bench_mem[wa][8*i +: 8] = bus_if.mem_wdata[8*i +: 8];
                    end
                    bus_if.mem_gnt = 1'b1;
                    @(negedge clk);
                    bus_if.mem_gnt = 1'b0;
                    if (!is_wr) begin
                        for (int k = 0; k < rd_dly; k++) @(negedge clk);
                        bus_if.mem_rvalid = 1'b1;
                        bus_if.mem_rdata  = bench_mem[wa];
                        @(negedge clk);
                        bus_if.mem_rvalid = 1'b0;
                        bus_if.mem_rdata  = $urandom;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] rand_size();
        int k = $urandom_range(0, 2);
        return (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
    endfunction

    initial begin
        logic [31:0] held;
        rst = 1'b1; rvalid = 0; wvalid = 0; op = 0; addr = 0; wdata = 0;
        wstrb = 4'b0001; is_atom = 0; flush = 0; llbit_clear = 0;
        for (int i = 0; i < 16; i++) begin
            model_mem[i] = $urandom;
            bench_mem[i] = model_mem[i];
        end
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_rready", {31'b0, rready}, 0);
        chk("rst_wready", {31'b0, wready}, 0);
        chk("rst_ale", {31'b0, ale}, 0);
        chk("rst_llbit", {31'b0, llbit}, 0);
        chk("rst_mem_req", {31'b0, bus_if.mem_req}, 0);
        chk("rst_mem_we", {31'b0, bus_if.mem_we}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", bus_if.mem_addr, 0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 0);
        chk("rst_mem_wstrb", {28'b0, bus_if.mem_wstrb}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Word read, minimum latency
        gnt_dly = 0; rd_dly = 0;
        model_mem[1] = 32'hDEADBEEF; bench_mem[1] = 32'hDEADBEEF;
        issue(0, 32'h1000_0004, 0, 4'b1111, 0, 1);
        wait_idle();
        chk("lat_read", resp_cyc - issue_cyc, 3);

        // Byte write at offset 3
        issue(1, 32'h1000_0003, 32'h0000_00A5, 4'b0001, 0, 1);
        wait_idle();
        chk("lat_write", resp_cyc - issue_cyc, 2);

        // Half read at offset 2, then misaligned half read
        model_mem[0] = 32'h12345678; bench_mem[0] = 32'h12345678;
        issue(0, 32'h1000_0002, 0, 4'b0011, 0, 1);
        wait_idle();
        saw_req = 0;
        issue(0, 32'h1000_0001, 0, 4'b0011, 0, 1);
        wait_idle();
        chk("lat_ale", resp_cyc - issue_cyc, 1);
        chk("ale_no_mem_req", {31'b0, saw_req}, 0);

        // LL then SC succeeds, second SC fails without bus activity
        issue(0, 32'h1000_0008, 0, 4'b1111, 1, 1);
        wait_idle();
        chk("llbit_after_ll", {31'b0, llbit}, 1);
        issue(1, 32'h1000_0008, 32'hCAFEF00D, 4'b1111, 1, 1);
        wait_idle();
        chk("llbit_after_sc", {31'b0, llbit}, 0);
        saw_req = 0;
        issue(1, 32'h1000_0008, 32'h11111111, 4'b1111, 1, 1);
        wait_idle();
        chk("lat_scfail", resp_cyc - issue_cyc, 1);
        chk("scfail_no_mem_req", {31'b0, saw_req}, 0);

        // LL completing while llbit_clear is held: clear wins
        llbit_clear = 1'b1;
        issue(0, 32'h1000_000C, 0, 4'b1111, 1, 1);
        wait_idle();
        llbit_clear = 1'b0;
        model_ll = 1'b0;
        @(negedge clk);
        chk("llbit_clear_wins", {31'b0, llbit}, 0);

        // Read flushed in WAIT, data 3 cycles after the flush
        gnt_dly = 0; rd_dly = 3;
        held = rdata;
        issue(0, 32'h1000_0010, 0, 4'b1111, 0, 0);
        @(negedge clk);             // cycle 2: WAIT
        flush = 1'b1;
        @(negedge clk);             // cycle 3
        flush = 1'b0;
        chk("drain_busy_c3", {31'b0, busy}, 1);
        @(negedge clk);
        chk("drain_busy_c4", {31'b0, busy}, 1);
        @(negedge clk);
        chk("drain_busy_c5", {31'b0, busy}, 1);
        @(negedge clk);
        chk("drain_idle_c6", {31'b0, busy}, 0);
        chk("drain_rdata_held", rdata, held);
        rd_dly = 0;
        issue(0, 32'h1000_0014, 0, 4'b1111, 0, 1);
        wait_idle();
        chk("lat_after_drain", resp_cyc - issue_cyc, 3);

        // Flush in REQ before grant: no response, bus released
        gnt_dly = 3;
        issue(0, 32'h1000_0018, 0, 4'b1111, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_req_mem_req", {31'b0, bus_if.mem_req}, 0);
        chk("flush_req_busy", {31'b0, busy}, 0);
        bus_q.delete();
        repeat (4) @(negedge clk);

        // Flush with grant on a write: committed, response suppressed
        gnt_dly = 0;
        issue(1, 32'h1000_001C, 32'h5A5A5A5A, 4'b1111, 0, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_gnt_wr_busy", {31'b0, busy}, 0);
        @(negedge clk);

        // Flush in IDLE drops a simultaneous request
        flush = 1'b1;
        issue(0, 32'h1000_0020, 0, 4'b1111, 0, 0);
        flush = 1'b0;
        chk("flush_idle_busy", {31'b0, busy}, 0);
        bus_q.delete();
        repeat (2) @(negedge clk);

        // Reset while in WAIT
        issue(0, 32'h1000_0024, 0, 4'b1111, 1, 1);
        wait_idle();
        chk("llbit_before_rst", {31'b0, llbit}, 1);
        rd_dly = 3;
        issue(0, 32'h1000_0028, 0, 4'b1111, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_ll = 1'b0;
        chk("wrst_busy", {31'b0, busy}, 0);
        chk("wrst_llbit", {31'b0, llbit}, 0);
        chk("wrst_mem_req", {31'b0, bus_if.mem_req}, 0);
        chk("wrst_rdata", rdata, 0);
        chk("wrst_mem_addr", bus_if.mem_addr, 0);
        chk("wrst_mem_wdata", bus_if.mem_wdata, 0);
        chk("wrst_mem_wstrb", {28'b0, bus_if.mem_wstrb}, 0);
        repeat (8) @(negedge clk);
        bus_q.delete();

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            bit          w, at;
            logic [31:0] a;
            gnt_dly = $urandom_range(0, 3);
            rd_dly  = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                llbit_clear = 1'b1;
                @(negedge clk);
                llbit_clear = 1'b0;
                model_ll = 1'b0;
            end
            w  = $urandom_range(0, 1);
            at = ($urandom_range(0, 3) == 0);
            a  = 32'h1000_0000 | 32'($urandom_range(0, 63));
            issue(w, a, $urandom, rand_size(), at, 1);
            wait_idle();
            chk("llbit", {31'b0, llbit}, {31'b0, model_ll});
        end

        repeat (4) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
